asym_fifo: RTL and testbench
============================

# asym_fifo

Synchronous FIFO with an asymmetric width ratio: each write pushes one wide word, and each read pops one narrow word. It generalises the fixed 2:1 asymmetric register file to any power-of-two ratio and adds full/empty tracking, an occupancy count, overflow/underflow flags and a synchronous clear. It sits in the FIFO buffer path between a wide producer (for example a packed bus) and a narrow consumer (for example a UART transmitter).

## Interface
- ADDR_WIDTH, 4, log2 of depth in narrow words; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, narrow (read) word width.
- RATIO_LOG2, 1, log2 of width ratio; RATIO = 2**RATIO_LOG2; legal range 0..3; ADDR_WIDTH > RATIO_LOG2 required.
- clk  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pointers and flags.
- wr  in  1  write request.
- w_data  in  RATIO*DATA_WIDTH  wide write word; slice 0 is the least significant DATA_WIDTH bits.
- rd  in  1  read request (pop).
- r_data  out  DATA_WIDTH  head narrow word, first-word-fall-through.
- full  out  1  fewer than RATIO free narrow slots.
- empty  out  1  zero narrow words stored.
- count  out  ADDR_WIDTH+1  narrow words stored, 0..DEPTH.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- rd_err  out  1  one-cycle pulse when a read is rejected.

## Operation
- Pointers:
  - w_ptr and r_ptr are each ADDR_WIDTH+1 bits, modular; count = w_ptr - r_ptr.
  - w_ptr always advances by RATIO and stays RATIO-aligned.
  - r_ptr advances by 1.
- Accepted write (wr && !full): slice k is stored at mem[w_ptr+k] for k = 0..RATIO-1, so narrow words leave in ascending slice order.
- Accepted read (rd && !empty): r_ptr increments.
- full = (count > DEPTH - RATIO). empty = (count == 0). Both are decoded from registered pointers only.
- Rejected write (wr && full): no state change except that wr_err pulses.
- Rejected read (rd && empty): no state change except that rd_err pulses.
- Simultaneous wr and rd:
  - Each is qualified against the pre-edge flags.
  - If both are accepted, count changes by RATIO-1.
  - When empty: the write is accepted and the read is rejected (rd_err pulses).
  - When full: the read is accepted and the write is rejected (wr_err pulses). The freed slot does not rescue the write in the same cycle.
- clr has priority over wr and rd: both pointers go to 0, the error flags go to 0, and memory is untouched.
- Wrap-around: pointer MSB toggling is transparent. Ordering is preserved across any number of wraps.
- Memory is not reset. r_data while empty is undefined and must not be checked.

## Timing
- Reset values (applied immediately when reset_n falls, independent of clk): empty=1, full=0, count=0, wr_err=0, rd_err=0, pointers 0.
- Write-to-read latency: one cycle. After a write at edge N into an empty FIFO, empty=0 and r_data = slice 0 after edge N.
- Read data: r_data is combinational from mem[r_ptr]. It reflects the next word after the edge that pops.
- Flags and count are valid after each edge and are stable for the whole cycle.
- wr_err and rd_err are registered and assert for exactly the cycle after the offending edge.
- Reset mid-burst: all in-flight state is discarded and the FIFO behaves as fresh after reset_n rises.

## Structure
- Package asym_fifo_pkg holds:
  - MAX_RATIO_LOG2 = 3.
  - typedef fifo_status_t, a packed struct {full, empty, wr_err, rd_err}, used internally for the flag register.
- Sub-module asym_reg_file_n holds the storage. It is parametrised by ADDR_WIDTH, DATA_WIDTH and RATIO_LOG2, has a RATIO-slice write port and an asynchronous narrow read port, and contains no reset.
- asym_fifo holds the pointers, flag logic, count and error pulses. It checks parameter legality with an elaboration-time assertion.

## Test plan
Configuration: ADDR_WIDTH=3, DATA_WIDTH=8, RATIO_LOG2=1 (DEPTH=8, RATIO=2) unless stated otherwise.
- Reset: hold reset_n low mid-cycle with no clk edge -> empty=1, full=0, count=0, wr_err=0, rd_err=0 immediately.
- Single word: write 16'hBBAA -> next cycle empty=0, count=2, r_data=8'hAA. Read -> r_data=8'hBB, count=1. Read -> empty=1, count=0.
- Fill and overflow:
  - Write 16'h0100, 16'h0302, 16'h0504, 16'h0706 -> full=1, count=8.
  - Fifth write -> ignored and wr_err high for one cycle.
  - Eight reads -> bytes 00..07 in order, then empty=1.
- Partial-free full: from count=8, one read -> count=7, full stays 1. Write during that state -> rejected, wr_err pulses, count stays 7.
- Simultaneous and underflow:
  - At count=2, wr+rd together -> count=3.
  - At empty, wr+rd together -> count=2, rd_err pulses.
  - At full, wr+rd together -> count=7, wr_err pulses.
- Wrap, clr and ratio sweep:
  - 40 random accepted writes interleaved with reads match a scoreboard order across wraps.
  - clr with count=5 -> count=0 and empty=1 next cycle.
  - Repeat the single-word and fill scenarios with RATIO_LOG2=0 and RATIO_LOG2=2 (32-bit write 32'h33221100 -> reads 00, 11, 22, 33).

Source files
------------

// File: rtl/asym_fifo_pkg.sv
// Shared definitions for the asymmetric-width FIFO: ratio limit and the
// packed status register layout.
package asym_fifo_pkg;

  localparam int MAX_RATIO_LOG2 = 3;

  typedef struct packed {
    logic full;
    logic empty;
    logic wr_err;
    logic rd_err;
  } fifo_status_t;

endpackage

// File: rtl/asym_reg_file_n.sv
// Storage for the asymmetric FIFO: one wide write of RATIO narrow slices per
// clock, asynchronous narrow read. No reset; contents are undefined until written.
module asym_reg_file_n
  import asym_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RATIO_LOG2 = 1
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [ADDR_WIDTH-1:0]                w_addr,
  input  logic [(DATA_WIDTH<<RATIO_LOG2)-1:0]  w_data,
  input  logic [ADDR_WIDTH-1:0]                r_addr,
  output logic [DATA_WIDTH-1:0]                r_data
);

  localparam int RATIO = 1 << RATIO_LOG2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Slice k lands at w_addr+k, so the least significant slice is read out first.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < RATIO; k++) begin
        mem[w_addr + ADDR_WIDTH'(k)] <= w_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/asym_fifo.sv
// Wide-in, narrow-out synchronous FIFO with occupancy count, overflow and
// underflow pulses, and a synchronous clear.
module asym_fifo
  import asym_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RATIO_LOG2 = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 clr,
  input  logic                                 wr,
  input  logic [(DATA_WIDTH<<RATIO_LOG2)-1:0]  w_data,
  input  logic                                 rd,
  output logic [DATA_WIDTH-1:0]                r_data,
  output logic                                 full,
  output logic                                 empty,
  output logic [ADDR_WIDTH:0]                  count,
  output logic                                 wr_err,
  output logic                                 rd_err
);

  localparam int RATIO = 1 << RATIO_LOG2;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_STEP   = (ADDR_WIDTH+1)'(RATIO);
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] FULL_LIMIT = (ADDR_WIDTH+1)'(DEPTH - RATIO);

  if (RATIO_LOG2 < 0 || RATIO_LOG2 > MAX_RATIO_LOG2 || ADDR_WIDTH <= RATIO_LOG2) begin : g_param_check
    $fatal(1, "asym_fifo: illegal RATIO_LOG2/ADDR_WIDTH combination");
  end

  logic [ADDR_WIDTH:0] w_ptr;
  logic [ADDR_WIDTH:0] r_ptr;
  logic [ADDR_WIDTH:0] w_ptr_next;
  logic [ADDR_WIDTH:0] r_ptr_next;
  logic [ADDR_WIDTH:0] count_next;
  fifo_status_t        status;
  logic                wr_ok;
  logic                rd_ok;

  assign wr_ok      = wr && !status.full;
  assign rd_ok      = rd && !status.empty;
  assign w_ptr_next = wr_ok ? w_ptr + PTR_STEP : w_ptr;
  assign r_ptr_next = rd_ok ? r_ptr + PTR_ONE : r_ptr;
  assign count_next = w_ptr_next - r_ptr_next;
  assign count      = w_ptr - r_ptr;

  // full/empty are registered from the next pointers, so they always equal a
  // decode of the current registered pointers and never see this cycle's inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      status <= '{full: 1'b0, empty: 1'b1, wr_err: 1'b0, rd_err: 1'b0};
    end else if (clr) begin
      w_ptr  <= '0;
      r_ptr  <= '0;
      status <= '{full: 1'b0, empty: 1'b1, wr_err: 1'b0, rd_err: 1'b0};
    end else begin
      w_ptr         <= w_ptr_next;
      r_ptr         <= r_ptr_next;
      status.full   <= count_next > FULL_LIMIT;
      status.empty  <= count_next == '0;
      status.wr_err <= wr && status.full;
      status.rd_err <= rd && status.empty;
    end
  end

  assign full   = status.full;
  assign empty  = status.empty;
  assign wr_err = status.wr_err;
  assign rd_err = status.rd_err;

  asym_reg_file_n #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RATIO_LOG2(RATIO_LOG2)
  ) u_mem (
    .clk    (clk),
    .we     (wr_ok && !clr),
    .w_addr (w_ptr[ADDR_WIDTH-1:0]),
    .w_data (w_data),
    .r_addr (r_ptr[ADDR_WIDTH-1:0]),
    .r_data (r_data)
  );

endmodule

// File: tb/tb_asym_fifo.sv
// Scoreboard bench for asym_fifo: three instances (ratio 1, 2, 4) exercised one
// at a time against a byte-queue reference model.
module tb_asym_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic [2:0]  clr_v;
  logic [2:0]  wr_v;
  logic [2:0]  rd_v;
  logic [31:0] w_data;
  logic [1:0]  sel;

  logic [7:0]  r_data_a [3];
  logic [3:0]  count_a  [3];
  logic [2:0]  full_v;
  logic [2:0]  empty_v;
  logic [2:0]  wr_err_v;
  logic [2:0]  rd_err_v;

  logic [7:0]  r_data_m;
  logic [3:0]  count_m;
  logic        full_m, empty_m, wr_err_m, rd_err_m, rd_m, clr_m;

  logic [7:0]  model_q [$];
  logic [7:0]  exp_q   [$];
  bit          exp_wr_err;
  bit          exp_rd_err;
  bit          last_wr_acc;
  int          checks;
  int          failures;

  asym_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO_LOG2(0)) u_dut_r1 (
    .clk(clk), .reset_n(reset_n), .clr(clr_v[0]), .wr(wr_v[0]), .w_data(w_data[7:0]),
    .rd(rd_v[0]), .r_data(r_data_a[0]), .full(full_v[0]), .empty(empty_v[0]),
    .count(count_a[0]), .wr_err(wr_err_v[0]), .rd_err(rd_err_v[0]));

  asym_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO_LOG2(1)) u_dut_r2 (
    .clk(clk), .reset_n(reset_n), .clr(clr_v[1]), .wr(wr_v[1]), .w_data(w_data[15:0]),
    .rd(rd_v[1]), .r_data(r_data_a[1]), .full(full_v[1]), .empty(empty_v[1]),
    .count(count_a[1]), .wr_err(wr_err_v[1]), .rd_err(rd_err_v[1]));

  asym_fifo #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .RATIO_LOG2(2)) u_dut_r4 (
    .clk(clk), .reset_n(reset_n), .clr(clr_v[2]), .wr(wr_v[2]), .w_data(w_data),
    .rd(rd_v[2]), .r_data(r_data_a[2]), .full(full_v[2]), .empty(empty_v[2]),
    .count(count_a[2]), .wr_err(wr_err_v[2]), .rd_err(rd_err_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    r_data_m = r_data_a[0];
    count_m  = count_a[0];
    full_m   = full_v[0];
    empty_m  = empty_v[0];
    wr_err_m = wr_err_v[0];
    rd_err_m = rd_err_v[0];
    rd_m     = rd_v[0];
    clr_m    = clr_v[0];
    case (sel)
      2'd1: begin
        r_data_m = r_data_a[1]; count_m = count_a[1]; full_m = full_v[1];
        empty_m = empty_v[1]; wr_err_m = wr_err_v[1]; rd_err_m = rd_err_v[1];
        rd_m = rd_v[1]; clr_m = clr_v[1];
      end
      2'd2: begin
        r_data_m = r_data_a[2]; count_m = count_a[2]; full_m = full_v[2];
        empty_m = empty_v[2]; wr_err_m = wr_err_v[2]; rd_err_m = rd_err_v[2];
        rd_m = rd_v[2]; clr_m = clr_v[2];
      end
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && rd_m && !clr_m && !empty_m) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rd_data actual=%h expected=<no pop> at %0t", r_data_m, $time);
      end else begin
        check("rd_data", {24'h0, r_data_m}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic check_output();
    int ratio_now = 1 << sel;
    check("count",  {28'h0, count_m}, model_q.size());
    check("full",   {31'h0, full_m},  {31'h0, model_q.size() > (DEPTH - ratio_now)});
    check("empty",  {31'h0, empty_m}, {31'h0, model_q.size() == 0});
    check("wr_err", {31'h0, wr_err_m}, {31'h0, exp_wr_err});
    check("rd_err", {31'h0, rd_err_m}, {31'h0, exp_rd_err});
    if (model_q.size() != 0) check("head", {24'h0, r_data_m}, {24'h0, model_q[0]});
  endtask

  // Called just after a rising edge; drives one cycle and checks after the next edge.
  task automatic apply_stimulus(input logic w, input logic r, input logic c, input logic [31:0] d);
    int ratio_now = 1 << sel;
    bit full_pre  = model_q.size() > (DEPTH - ratio_now);
    bit empty_pre = model_q.size() == 0;
    wr_v   = w ? (3'b001 << sel) : 3'b000;
    rd_v   = r ? (3'b001 << sel) : 3'b000;
    clr_v  = c ? (3'b001 << sel) : 3'b000;
    w_data = d;
    exp_wr_err  = 1'b0;
    exp_rd_err  = 1'b0;
    last_wr_acc = 1'b0;
    if (c) begin
      model_q.delete();
    end else begin
      if (r && !empty_pre) exp_q.push_back(model_q.pop_front());
      if (w && !full_pre) begin
        for (int k = 0; k < ratio_now; k++) model_q.push_back(d[k*8 +: 8]);
        last_wr_acc = 1'b1;
      end
      exp_wr_err = w && full_pre;
      exp_rd_err = r && empty_pre;
    end
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs are checked before any edge.
  task automatic do_reset();
    wr_v = '0; rd_v = '0; clr_v = '0;
    #1;
    reset_n = 1'b0;
    #1;
    model_q.delete();
    exp_q.delete();
    exp_wr_err = 1'b0;
    exp_rd_err = 1'b0;
    check_output();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] fill_word(input int j, input int ratio_now);
    logic [31:0] wv = '0;
    for (int k = 0; k < ratio_now; k++) wv[k*8 +: 8] = 8'(j*ratio_now + k);
    return wv;
  endfunction

  task automatic single_word(input logic [31:0] d);
    int ratio_now = 1 << sel;
    apply_stimulus(1'b1, 1'b0, 1'b0, d);
    for (int i = 0; i < ratio_now; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    idle();
  endtask

  task automatic fill_drain();
    int ratio_now = 1 << sel;
    for (int j = 0; j < DEPTH / ratio_now; j++) apply_stimulus(1'b1, 1'b0, 1'b0, fill_word(j, ratio_now));
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
    idle();
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    idle();
  endtask

  task automatic random_traffic(input int accepted_target, input int budget);
    int accepted = 0;
    int cycles   = 0;
    while (accepted < accepted_target && cycles < budget) begin
      apply_stimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50, 1'b0, $urandom);
      if (last_wr_acc) accepted++;
      cycles++;
    end
    check("random_writes_accepted", accepted, accepted_target);
  endtask

  initial begin
    checks = 0; failures = 0;
    sel = 2'd1;
    wr_v = '0; rd_v = '0; clr_v = '0; w_data = '0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Ratio 2: directed corner cases, then random traffic across many wraps.
    single_word(32'h0000BBAA);
    fill_drain();
    for (int j = 0; j < 4; j++) apply_stimulus(1'b1, 1'b0, 1'b0, fill_word(j, 2));
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000EEFF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h00001211);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h00001413);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h00002221);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    for (int j = 0; j < 4; j++) apply_stimulus(1'b1, 1'b0, 1'b0, fill_word(j + 4, 2));
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h00003231);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 32'h0);
    idle();
    random_traffic(40, 1000);
    do_reset();

    // Ratio 1.
    sel = 2'd0;
    #1;
    single_word(32'h000000AA);
    fill_drain();
    random_traffic(20, 500);
    do_reset();

    // Ratio 4.
    sel = 2'd2;
    #1;
    single_word(32'h33221100);
    fill_drain();
    random_traffic(20, 500);
    do_reset();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
